// File: rtl/cpu_pkg.sv
// Shared types and encodings for the Simple RISC control stage.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic [1:0] WB_MDATA = 2'b00;
    localparam logic [1:0] WB_IMM8  = 2'b01;
    localparam logic [1:0] WB_PC    = 2'b10;
    localparam logic [1:0] WB_C     = 2'b11;

endpackage

// File: rtl/instr_decoder.sv
// Combinational IR field extraction, sign extension and legality.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [1:0]  sh,
    output logic [2:0]  rm,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic        is_mov_imm,
    output logic        is_mov_reg,
    output logic        is_add,
    output logic        is_cmp,
    output logic        is_and,
    output logic        is_mvn,
    output logic        legal
);

    logic [2:0] opcode;
    logic       mov_grp;
    logic       alu_grp;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};

    assign mov_grp = (opcode == OPC_MOV);
    assign alu_grp = (opcode == OPC_ALU);

    assign is_mov_imm = mov_grp && (op == OP_MOV_IMM);
    assign is_mov_reg = mov_grp && (op == OP_MOV_REG);
    assign is_add     = alu_grp && (op == OP_ADD);
    assign is_cmp     = alu_grp && (op == OP_CMP);
    assign is_and     = alu_grp && (op == OP_AND);
    assign is_mvn     = alu_grp && (op == OP_MVN);

    assign legal = is_mov_imm | is_mov_reg | alu_grp;

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus multi-cycle datapath sequencer.
// Optional sticky `illegal` output: define CPU_CTRL_ILLEGAL_FLAG_EN.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    output logic               waiting,
`ifdef CPU_CTRL_ILLEGAL_FLAG_EN
    output logic               illegal,
`endif
    output logic [2:0]         r_addr,
    output logic [2:0]         w_addr,
    output logic               w_en,
    output logic [1:0]         wb_sel,
    output logic               en_A,
    output logic               en_B,
    output logic               en_C,
    output logic               en_status,
    output logic               sel_A,
    output logic               sel_B,
    output logic [1:0]         shift_op,
    output logic [1:0]         ALU_op,
    output logic [15:0]        sximm8,
    output logic [15:0]        sximm5
);

    if (INSTR_W != 16) begin : g_bad_width
        $error("cpu_controller: INSTR_W must be 16");
    end

    state_t     state;
    state_t     state_nx;
    logic [15:0] ir;

    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
    logic       is_mov_imm;
    logic       is_mov_reg;
    logic       is_add;
    logic       is_cmp;
    logic       is_and;
    logic       is_mvn;
    logic       legal;

    instr_decoder u_dec (
        .ir         (ir),
        .op         (op),
        .rn         (rn),
        .rd         (rd),
        .sh         (sh),
        .rm         (rm),
        .sximm8     (sximm8),
        .sximm5     (sximm5),
        .is_mov_imm (is_mov_imm),
        .is_mov_reg (is_mov_reg),
        .is_add     (is_add),
        .is_cmp     (is_cmp),
        .is_and     (is_and),
        .is_mvn     (is_mvn),
        .legal      (legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (load && state == S_WAIT)
                ir <= instr;
        end
    end

`ifdef CPU_CTRL_ILLEGAL_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst)
            illegal <= 1'b0;
        else if (state == S_DECODE && !legal)
            illegal <= 1'b1;
    end
`endif

    assign waiting  = (state == S_WAIT);
    // MOV imm reuses the sh bits as immediate data, so no shift there.
    assign shift_op = is_mov_imm ? 2'b00 : sh;

    always_comb begin
        state_nx  = state;
        r_addr    = 3'd0;
        w_addr    = 3'd0;
        w_en      = 1'b0;
        wb_sel    = WB_MDATA;
        en_A      = 1'b0;
        en_B      = 1'b0;
        en_C      = 1'b0;
        en_status = 1'b0;
        sel_A     = 1'b0;
        sel_B     = 1'b0;
        ALU_op    = ALU_ADD;
        unique case (state)
            S_WAIT: begin
                if (start)
                    state_nx = S_DECODE;
            end
            S_DECODE: begin
                state_nx = S_WAIT;
                if (legal) begin
                    unique case (1'b1)
                        is_mov_imm:             state_nx = S_WRITE_IMM;
                        is_mov_reg, is_mvn:     state_nx = S_GET_B;
                        is_add, is_cmp, is_and: state_nx = S_GET_A;
                        default:                state_nx = S_WAIT;
                    endcase
                end
            end
            S_GET_A: begin
                r_addr   = rn;
                en_A     = 1'b1;
                state_nx = S_GET_B;
            end
            S_GET_B: begin
                r_addr   = rm;
                en_B     = 1'b1;
                state_nx = S_ALU;
            end
            S_ALU: begin
                ALU_op    = is_mov_reg ? ALU_ADD : op;
                sel_A     = is_mov_reg | is_mvn;
                en_C      = !is_cmp;
                en_status = is_cmp;
                state_nx  = is_cmp ? S_WAIT : S_WRITE_REG;
            end
            S_WRITE_REG: begin
                w_addr   = rd;
                wb_sel   = WB_C;
                w_en     = 1'b1;
                state_nx = S_WAIT;
            end
            S_WRITE_IMM: begin
                w_addr   = rn;
                wb_sel   = WB_IMM8;
                w_en     = 1'b1;
                state_nx = S_WAIT;
            end
            default: state_nx = S_WAIT;
        endcase
    end

endmodule
